// File: rtl/mm_uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter:
// register offsets, FSM state encodings, status bit positions.
package mm_uart_pkg;

   localparam logic [1:0] OFF_DATA   = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_DIV    = 2'd2;
   localparam logic [1:0] OFF_CTRL   = 2'd3;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_START = 2'd1;
   localparam state_t ST_DATA  = 2'd2;
   localparam state_t ST_STOP  = 2'd3;

   localparam logic [15:0] DEFAULT_DIV = 16'd434;

   localparam int STAT_IDLE  = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_EMPTY = 2;
   localparam int STAT_OVF   = 3;

   // A divisor of zero would never end a bit, so it runs as one.
   function automatic logic [15:0] eff_div(input logic [15:0] d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction

endpackage

// File: rtl/mm_uart_tx_fifo.sv
// Synchronous FIFO with extra-bit pointers; a push into a full
// FIFO succeeds when a pop happens on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_pop;
   logic             do_push;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   // Pointer update; the extra MSB tells full from empty on wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset since pointers gate them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/mm_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode,
// sticky overflow, baud divisor and the serialiser FSM.
module mm_uart_tx #(
   parameter logic [15:0] BASE_ADDR   = 16'hC000,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = mm_uart_pkg::DEFAULT_DIV
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   input  logic        mm_we,
   input  logic        mm_re,
   output logic [15:0] rdata,
   output logic        TX,
   output logic        tx_idle
);

   import mm_uart_pkg::*;

   logic        sel;
   logic [1:0]  offset;
   logic        wr_data;
   logic        wr_div;
   logic        wr_ctrl;

   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_pop;
   logic [7:0]  fifo_dout;
   logic        ovf_set;
   logic        ovf_clr;

   logic [15:0] div_reg;
   logic        overflow;
   logic [15:0] status;

   state_t      state;
   logic [15:0] div_lat;
   logic [15:0] cnt;
   logic [2:0]  idx;
   logic [2:0]  nxt_idx;
   logic [7:0]  shift;
   logic        tx_q;
   logic [15:0] new_div;
   logic        bit_end;

   assign sel    = (addr[15:2] == BASE_ADDR[15:2]);
   assign offset = addr[1:0];

   assign wr_data = mm_we & sel & (offset == OFF_DATA);
   assign wr_div  = mm_we & sel & (offset == OFF_DIV);
   assign wr_ctrl = mm_we & sel & (offset == OFF_CTRL);

   assign bit_end = (cnt == 16'd0);
   assign nxt_idx = idx + 3'd1;
   assign new_div = eff_div(div_reg);

   // Pop when idle with data, or when a stop bit ends with more data.
   assign fifo_pop = ~fifo_empty &
                     ((state == ST_IDLE) |
                      ((state == ST_STOP) & bit_end));

   assign ovf_set = wr_data & fifo_full & ~fifo_pop;
   assign ovf_clr = wr_ctrl & wdata[0];

   assign tx_idle = fifo_empty & (state == ST_IDLE);
   assign TX      = tx_q;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_data),
      .pop   (fifo_pop),
      .din   (wdata[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Divisor register and sticky overflow; a new overflow beats a clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_reg  <= DEFAULT_DIV;
         overflow <= 1'b0;
      end else begin
         if (wr_div) div_reg <= wdata;
         if (ovf_set)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   // Status word assembled from live flags.
   always_comb begin
      status            = '0;
      status[STAT_IDLE]  = tx_idle;
      status[STAT_FULL]  = fifo_full;
      status[STAT_EMPTY] = fifo_empty;
      status[STAT_OVF]   = overflow;
   end

   // Combinational read mux; reads have no side effects.
   always_comb begin
      rdata = '0;
      if (mm_re & sel) begin
         unique case (offset)
            OFF_STATUS: rdata = status;
            OFF_DIV:    rdata = div_reg;
            default:    rdata = '0;
         endcase
      end
   end

   // Serialiser: start, eight data bits LSB first, stop; TX registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         tx_q    <= 1'b1;
         cnt     <= '0;
         idx     <= '0;
         shift   <= '0;
         div_lat <= 16'd1;
      end else begin
         unique case (state)
            ST_IDLE: begin
               tx_q <= 1'b1;
               if (!fifo_empty) begin
                  shift   <= fifo_dout;
                  div_lat <= new_div;
                  cnt     <= new_div - 16'd1;
                  tx_q    <= 1'b0;
                  state   <= ST_START;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  cnt   <= div_lat - 16'd1;
                  idx   <= 3'd0;
                  tx_q  <= shift[0];
                  state <= ST_DATA;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  cnt <= div_lat - 16'd1;
                  if (idx == 3'd7) begin
                     tx_q  <= 1'b1;
                     state <= ST_STOP;
                  end else begin
                     idx  <= nxt_idx;
                     tx_q <= shift[nxt_idx];
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  if (!fifo_empty) begin
                     shift   <= fifo_dout;
                     div_lat <= new_div;
                     cnt     <= new_div - 16'd1;
                     tx_q    <= 1'b0;
                     state   <= ST_START;
                  end else begin
                     tx_q  <= 1'b1;
                     state <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: begin
               tx_q  <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mm_uart_tx.sv
// Scoreboarded bench for mm_uart_tx: stimulus queues expected
// bytes, a serial receiver pops and compares each frame.
module tb_mm_uart_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] addr = '0;
   logic [15:0] wdata = '0;
   logic        mm_we = 1'b0;
   logic        mm_re = 1'b0;
   logic [15:0] rdata;
   logic        TX;
   logic        tx_idle;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];
   int mon_div = 4;

   mm_uart_tx dut (
      .clk     (clk),
      .rst     (rst),
      .addr    (addr),
      .wdata   (wdata),
      .mm_we   (mm_we),
      .mm_re   (mm_re),
      .rdata   (rdata),
      .TX      (TX),
      .tx_idle (tx_idle)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act,
                        input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bus helpers: called just after a negedge.
   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      addr = a; wdata = d; mm_we = 1'b1;
      @(negedge clk);
      mm_we = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] d);
      addr = a; mm_re = 1'b1;
      #1;
      d = rdata;
      mm_re = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!tx_idle && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check(name, {15'd0, tx_idle}, 16'd1);
   endtask

   // Serial receiver / scoreboard monitor.
   int         rx_cnt = -1;
   int         rx_div = 4;
   logic [7:0] rx_byte;
   always @(negedge clk) begin
      int k;
      if (rst) begin
         rx_cnt = -1;
      end else if (rx_cnt < 0) begin
         if (TX === 1'b0) begin
            rx_cnt  = 0;
            rx_byte = '0;
            rx_div  = mon_div;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt == rx_div / 2)
            check("rx_start", {15'd0, TX}, 16'd0);
         if (rx_cnt >= rx_div && (rx_cnt % rx_div) == rx_div / 2) begin
            k = rx_cnt / rx_div - 1;
            if (k < 8) begin
               rx_byte[k] = TX;
            end else begin
               check("rx_stop", {15'd0, TX}, 16'd1);
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL rx_frame: got %h expected none", rx_byte);
               end else begin
                  logic [7:0] e;
                  e = exp_q.pop_front();
                  if (rx_byte !== e) begin
                     errors++;
                     $display("FAIL rx_frame: got %h expected %h", rx_byte, e);
                  end
               end
               rx_cnt = -1;
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] v;
      logic [7:0]  b;
      logic        e;
      int          n;
      int          bad;

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx", {15'd0, TX}, 16'd1);
      check("rst_idle", {15'd0, tx_idle}, 16'd1);
      rst = 1'b0;
      rd(16'hC001, v); check("rst_status", v, 16'h0005);
      rd(16'hC002, v); check("rst_div", v, 16'd434);

      // Single 0xA5 frame, div 4, cycle-exact waveform
      mon_div = 4;
      wr(16'hC002, 16'd4);
      b = 8'hA5;
      exp_q.push_back(b);
      wr(16'hC000, 16'h00A5);
      for (int c = 1; c <= 41; c++) begin
         @(negedge clk);
         if (c <= 4)       e = 1'b0;
         else if (c <= 36) e = b[(c - 5) / 4];
         else              e = 1'b1;
         check($sformatf("a5_tx_c%0d", c), {15'd0, TX}, {15'd0, e});
         check($sformatf("a5_idle_c%0d", c), {15'd0, tx_idle},
               (c <= 40) ? 16'd0 : 16'd1);
      end

      // Overflow: ten back-to-back pushes, the tenth hits a full FIFO
      mon_div = 2;
      wr(16'hC002, 16'd2);
      for (int i = 0; i < 10; i++) begin
         if (i < 9) exp_q.push_back(8'(i));
         wr(16'hC000, 16'(i));
      end
      rd(16'hC001, v); check("ovf_status", v, 16'h000A);
      wr(16'hC003, 16'h0001);
      rd(16'hC001, v); check("ovf_clear", v, 16'h0002);
      repeat (10) @(negedge clk);
      // This edge ends the first frame's stop bit: pop + push on full.
      exp_q.push_back(8'h0A);
      wr(16'hC000, 16'h000A);
      rd(16'hC001, v); check("full_pop_push", v, 16'h0002);
      wait_idle("ovf_drain");
      rd(16'hC001, v); check("ovf_end_status", v, 16'h0005);

      // Twenty paced pushes to wrap the pointers
      for (int i = 0; i < 20; i++) begin
         n = 0;
         rd(16'hC001, v);
         while (v[1] && n < 2000) begin
            @(negedge clk);
            rd(16'hC001, v);
            n++;
         end
         if (n >= 2000) check("wrap_pace", 16'(n), 16'd0);
         b = 8'(i * 29) ^ 8'h5A;
         exp_q.push_back(b);
         wr(16'hC000, {8'h00, b});
      end
      wait_idle("wrap_drain");
      rd(16'hC001, v); check("wrap_status", v, 16'h0005);
      check("wrap_queue", 16'(exp_q.size()), 16'd0);

      // Decode: foreign addresses and non-readable offsets
      rd(16'hC005, v); check("rd_c005", v, 16'h0000);
      rd(16'hB001, v); check("rd_b001", v, 16'h0000);
      rd(16'hC000, v); check("rd_data", v, 16'h0000);
      rd(16'hC003, v); check("rd_ctrl", v, 16'h0000);
      addr = 16'hC002; mm_re = 1'b0; #1;
      check("rd_no_re", rdata, 16'h0000);
      wr(16'h4000, 16'h0055);
      wr(16'hC006, 16'h0007);
      repeat (3) @(negedge clk);
      check("we_foreign_idle", {15'd0, tx_idle}, 16'd1);
      rd(16'hC001, v); check("we_foreign_status", v, 16'h0005);
      rd(16'hC002, v); check("we_foreign_div", v, 16'd2);

      // Reset during data bit 3
      mon_div = 4;
      wr(16'hC002, 16'd4);
      exp_q.push_back(8'h00);
      wr(16'hC000, 16'h0000);
      repeat (18) @(negedge clk);
      check("pre_rst_tx", {15'd0, TX}, 16'd0);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("mid_rst_tx", {15'd0, TX}, 16'd1);
      check("mid_rst_idle", {15'd0, tx_idle}, 16'd1);
      rd(16'hC001, v); check("mid_rst_status", v, 16'h0005);
      rd(16'hC002, v); check("mid_rst_div", v, 16'd434);
      rst = 1'b0;
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (TX !== 1'b1) bad++;
      end
      check("post_rst_quiet", 16'(bad), 16'd0);
      check("final_queue", 16'(exp_q.size()), 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
